// File: rtl/apb_rr_master_if.sv
// ============================================================================
// Module   : apb_rr_master_if
// Purpose  : Requester command/response channels plus the APB bus of the
//            two-requester round-robin APB master.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface apb_rr_master_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 8
);
  logic [1:0]          req_valid;
  logic [1:0]          req_ready;
  logic [2*ADDR_W-1:0] req_addr;
  logic [1:0]          req_write;
  logic [2*DATA_W-1:0] req_wdata;
  logic [1:0]          rsp_valid;
  logic [DATA_W-1:0]   rsp_rdata;
  logic                rsp_err;
  logic                psel;
  logic                penable;
  logic [ADDR_W-1:0]   paddr;
  logic                pwrite;
  logic [DATA_W-1:0]   pwdata;
  logic [DATA_W-1:0]   prdata;
  logic                pready;
  logic                pslverr;

  modport master (
    input  req_valid, req_addr, req_write, req_wdata, prdata, pready, pslverr,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
           psel, penable, paddr, pwrite, pwdata
  );

  modport slave (
    output req_valid, req_addr, req_write, req_wdata, prdata, pready, pslverr,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
           psel, penable, paddr, pwrite, pwdata
  );
endinterface

`default_nettype wire

// File: rtl/apb_rr_master.sv
// ============================================================================
// Module   : apb_rr_master
// Purpose  : Shares one APB slave between two requesters with round-robin
//            arbitration and routes each result back to its owner.
//            Optional: define APB_TIMEOUT_EN to abort stalled ACCESS phases.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module apb_rr_master #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 8,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic            pclk,
  input  logic            preset,
  apb_rr_master_if.master bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_rr_ptr;
  logic                r_owner;
  logic [ADDR_W-1:0]   r_paddr;
  logic                r_pwrite;
  logic [DATA_W-1:0]   r_pwdata;
  logic [1:0]          r_rsp_valid;
  logic [DATA_W-1:0]   r_rsp_rdata;
  logic                r_rsp_err;
  logic                w_winner;
  logic                w_accept;
  logic                w_done;
  logic                w_abort;
  logic [1:0]          w_req_ready;

  // A lone requester always wins; the pointer only breaks ties.
  always_comb begin
    w_winner = bus.req_valid[1];
    if (bus.req_valid == 2'b11) begin
      w_winner = r_rr_ptr;
    end
  end

`ifdef APB_TIMEOUT_EN
  localparam int c_TO_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  localparam logic [c_TO_W-1:0] c_TO_LAST = c_TO_W'(TIMEOUT_CYCLES - 1);

  logic [c_TO_W-1:0] r_to_cnt;

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      r_to_cnt <= '0;
    end else if (r_state == S_SETUP) begin
      r_to_cnt <= '0;
    end else if ((r_state == S_ACCESS) && !bus.pready) begin
      r_to_cnt <= r_to_cnt + 1'b1;
    end
  end

  // Abort on the wait cycle that would be the limit-th one; pready still wins.
  assign w_abort = (r_state == S_ACCESS) && !bus.pready && (r_to_cnt == c_TO_LAST);
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT_CYCLES != 0);
  assign w_abort          = 1'b0;
`endif

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_req_ready = 2'b00;
    w_accept    = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (|bus.req_valid) begin
          w_accept              = 1'b1;
          w_req_ready[w_winner] = 1'b1;
          w_state_nxt           = S_SETUP;
        end
      end
      S_SETUP: begin
        w_state_nxt = S_ACCESS;
      end
      S_ACCESS: begin
        if (bus.pready) begin
          w_done      = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (w_abort) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      r_rr_ptr    <= 1'b0;
      r_owner     <= 1'b0;
      r_paddr     <= '0;
      r_pwrite    <= 1'b0;
      r_pwdata    <= '0;
      r_rsp_valid <= 2'b00;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_rsp_valid <= 2'b00;
      if (w_accept) begin
        r_owner  <= w_winner;
        r_rr_ptr <= ~w_winner;
        r_paddr  <= w_winner ? bus.req_addr[2*ADDR_W-1:ADDR_W] : bus.req_addr[ADDR_W-1:0];
        r_pwrite <= bus.req_write[w_winner];
        if (bus.req_write[w_winner]) begin
          r_pwdata <= w_winner ? bus.req_wdata[2*DATA_W-1:DATA_W] : bus.req_wdata[DATA_W-1:0];
        end else begin
          r_pwdata <= '0;
        end
      end
      if (w_done || w_abort) begin
        r_rsp_valid[r_owner] <= 1'b1;
        r_rsp_err            <= w_done ? bus.pslverr : 1'b1;
        r_rsp_rdata          <= (w_done && !r_pwrite && !bus.pslverr) ? bus.prdata : '0;
      end
    end
  end

  assign bus.req_ready = w_req_ready;
  assign bus.psel      = (r_state != S_IDLE);
  assign bus.penable   = (r_state == S_ACCESS);
  assign bus.paddr     = r_paddr;
  assign bus.pwrite    = r_pwrite;
  assign bus.pwdata    = r_pwdata;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_rdata = r_rsp_rdata;
  assign bus.rsp_err   = r_rsp_err;

endmodule

`default_nettype wire

// File: tb/tb_apb_rr_master.sv
// ============================================================================
// Module   : tb_apb_rr_master
// Purpose  : Directed, self-checking bench for apb_rr_master with a
//            transaction-level reference model and a memory-backed APB slave.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_apb_rr_master;
  localparam int ADDR_W         = 32;
  localparam int DATA_W         = 8;
  localparam int TIMEOUT_CYCLES = 16;

  typedef struct packed {
    logic        wr;
    logic [31:0] addr;
    logic [7:0]  wdata;
  } cmd_t;

  logic pclk   = 1'b0;
  logic preset = 1'b1;
  always #5 pclk = ~pclk;

  apb_rr_master_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  apb_rr_master #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .pclk(pclk), .preset(preset), .bus(bus)
  );

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int pen_cnt = 0;
  int psel_cyc = -1;
  int pen_cyc = -1;
  int slv_waits = 0;
  bit slv_err = 1'b0;
  logic [7:0] mem [256];

  cmd_t q0[$];
  cmd_t q1[$];
  logic [1:0] acc_mask = 2'b00;
  int acc_own[$];
  int acc_cyc[$];
  int rsp_vec[$];
  int rsp_cyc[$];
  int rsp_dat[$];
  int rsp_er[$];

  // Reference model: one outstanding transfer, tracked by its spec phase
  int         m_phase = 0;
  bit         m_rr = 1'b0;
  bit         m_owner = 1'b0;
  bit         m_write = 1'b0;
  logic [31:0] m_addr = '0;
  logic [7:0] m_wdata = '0;
  logic [7:0] m_rdata = '0;
  logic [1:0] m_rsp = 2'b00;
  bit         m_err = 1'b0;
  int         m_wait = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  initial begin : compare
    logic [1:0] exp_ready;
    bit w;
    forever begin
      @(negedge pclk);
      cyc++;
      if (preset) begin
        chk("rst_psel", bus.psel, 0);
        chk("rst_penable", bus.penable, 0);
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        chk("rst_rsp_rdata", bus.rsp_rdata, 0);
        chk("rst_rsp_err", bus.rsp_err, 0);
        m_phase = 0; m_rr = 0; m_rsp = 0; m_rdata = 0; m_err = 0; m_wait = 0;
        acc_mask = 2'b00;
      end else begin
        exp_ready = 2'b00;
        w = 1'b0;
        if (m_phase == 0 && bus.req_valid != 2'b00) begin
          w = (bus.req_valid == 2'b11) ? m_rr : bus.req_valid[1];
          exp_ready[w] = 1'b1;
        end
        chk("req_ready", bus.req_ready, exp_ready);
        chk("psel", bus.psel, (m_phase != 0));
        chk("penable", bus.penable, (m_phase == 2));
        if (m_phase != 0) begin
          chk("paddr", bus.paddr, m_addr);
          chk("pwrite", bus.pwrite, m_write);
          chk("pwdata", bus.pwdata, m_wdata);
        end
        chk("rsp_valid", bus.rsp_valid, m_rsp);
        chk("rsp_rdata", bus.rsp_rdata, m_rdata);
        chk("rsp_err", bus.rsp_err, m_err);

        if (bus.penable) pen_cnt++;
        if (bus.psel && psel_cyc < 0) psel_cyc = cyc;
        if (bus.penable && pen_cyc < 0) pen_cyc = cyc;
        if (bus.rsp_valid != 2'b00) begin
          rsp_vec.push_back(int'(bus.rsp_valid));
          rsp_cyc.push_back(cyc);
          rsp_dat.push_back(int'(bus.rsp_rdata));
          rsp_er.push_back(int'(bus.rsp_err));
        end
        acc_mask = bus.req_valid & bus.req_ready;
        if (acc_mask != 2'b00) begin
          acc_own.push_back(acc_mask[1] ? 1 : 0);
          acc_cyc.push_back(cyc);
        end

        // Advance the model to what the coming edge must produce
        m_rsp = 2'b00;
        if (m_phase == 0) begin
          if (bus.req_valid != 2'b00) begin
            m_owner = w;
            m_rr    = ~w;
            m_addr  = w ? bus.req_addr[63:32] : bus.req_addr[31:0];
            m_write = bus.req_write[w];
            m_wdata = m_write ? (w ? bus.req_wdata[15:8] : bus.req_wdata[7:0]) : 8'h00;
            m_phase = 1;
          end
        end else if (m_phase == 1) begin
          m_phase = 2;
          m_wait  = 0;
        end else begin
          if (bus.pready) begin
            m_phase = 0;
            m_rsp   = 2'b01 << m_owner;
            m_err   = bus.pslverr;
            m_rdata = (!m_write && !bus.pslverr) ? bus.prdata : 8'h00;
          end
`ifdef APB_TIMEOUT_EN
          else if (m_wait == TIMEOUT_CYCLES - 1) begin
            m_phase = 0;
            m_rsp   = 2'b01 << m_owner;
            m_err   = 1'b1;
            m_rdata = 8'h00;
          end
`endif
          else begin
            m_wait++;
          end
        end
      end
    end
  end

  // APB slave: memory backed, junk on the bus outside ACCESS
  initial begin : slave
    int acc;
    acc = 0;
    bus.pready = 1'b1; bus.pslverr = 1'b1; bus.prdata = 8'h5A;
    forever begin
      @(posedge pclk); #1;
      if (bus.psel && bus.penable) begin
        acc++;
        if (acc > slv_waits) begin
          bus.pready  = 1'b1;
          bus.pslverr = slv_err;
          bus.prdata  = slv_err ? 8'hEE : mem[bus.paddr[7:0]];
          if (bus.pwrite && !slv_err) mem[bus.paddr[7:0]] = bus.pwdata;
        end else begin
          bus.pready = 1'b0; bus.pslverr = 1'b1; bus.prdata = 8'hC3;
        end
      end else begin
        acc = 0;
        bus.pready = 1'b1; bus.pslverr = 1'b1; bus.prdata = 8'h5A;
      end
    end
  end

  task automatic drive();
    bus.req_valid[0] = (q0.size() != 0);
    bus.req_valid[1] = (q1.size() != 0);
    if (q0.size() != 0) begin
      bus.req_write[0] = q0[0].wr; bus.req_addr[31:0] = q0[0].addr; bus.req_wdata[7:0] = q0[0].wdata;
    end
    if (q1.size() != 0) begin
      bus.req_write[1] = q1[0].wr; bus.req_addr[63:32] = q1[0].addr; bus.req_wdata[15:8] = q1[0].wdata;
    end
  endtask

  task automatic step();
    @(posedge pclk); #1;
    if (acc_mask[0] && q0.size() != 0) void'(q0.pop_front());
    if (acc_mask[1] && q1.size() != 0) void'(q1.pop_front());
    drive();
  endtask

  task automatic push(input int n, input bit wr, input logic [31:0] addr, input logic [7:0] wd);
    cmd_t c;
    c.wr = wr; c.addr = addr; c.wdata = wd;
    if (n == 0) q0.push_back(c); else q1.push_back(c);
    drive();
  endtask

  task automatic run_quiet(input int max);
    int n;
    n = 0;
    while ((q0.size() != 0 || q1.size() != 0 || m_phase != 0) && n < max) begin
      step();
      n++;
    end
    n_chk++;
    if (n >= max) begin
      n_fail++;
      $display("FAIL run_bound: still busy after %0d cycles, required idle", n);
    end
    repeat (2) step();
  endtask

  task automatic wait_penable(input int max);
    int n;
    n = 0;
    while (!bus.penable && n < max) begin
      step();
      n++;
    end
    chk("wait_penable", bus.penable, 1);
  endtask

  task automatic clear_logs();
    acc_own.delete(); acc_cyc.delete();
    rsp_vec.delete(); rsp_cyc.delete(); rsp_dat.delete(); rsp_er.delete();
    pen_cnt = 0; psel_cyc = -1; pen_cyc = -1;
  endtask

  task automatic do_reset();
    preset = 1'b1;
    q0.delete(); q1.delete();
    drive();
    repeat (3) step();
    preset = 1'b0;
  endtask

  initial begin : main
    int exp_ord [4];
    exp_ord = '{0, 1, 0, 1};
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    bus.req_valid = '0; bus.req_addr = '0; bus.req_write = '0; bus.req_wdata = '0;
    repeat (3) @(posedge pclk);
    #1 preset = 1'b0;
    chk("reset_psel", bus.psel, 0);
    chk("reset_paddr", bus.paddr, 0);
    chk("reset_pwdata", bus.pwdata, 0);

    // 1: write then read back through requester 0
    clear_logs();
    push(0, 1'b1, 32'h3, 8'hA5);
    run_quiet(50);
    chk("t1_rsp_count", rsp_vec.size(), 1);
    if (rsp_vec.size() == 1 && acc_cyc.size() == 1) begin
      chk("t1_psel_lat", psel_cyc - acc_cyc[0], 1);
      chk("t1_penable_lat", pen_cyc - acc_cyc[0], 2);
      chk("t1_rsp_lat", rsp_cyc[0] - acc_cyc[0], 3);
      chk("t1_rsp_vec", rsp_vec[0], 1);
      chk("t1_rsp_err", rsp_er[0], 0);
    end
    clear_logs();
    push(0, 1'b0, 32'h3, 8'h00);
    run_quiet(50);
    chk("t1_rd_count", rsp_vec.size(), 1);
    if (rsp_vec.size() == 1) begin
      chk("t1_rd_data", rsp_dat[0], 8'hA5);
      chk("t1_rd_err", rsp_er[0], 0);
    end

    // 2: both requesters continuously valid after reset
    do_reset();
    clear_logs();
    push(0, 1'b1, 32'h10, 8'h01); push(0, 1'b1, 32'h11, 8'h02);
    push(1, 1'b1, 32'h12, 8'h03); push(1, 1'b1, 32'h13, 8'h04);
    run_quiet(100);
    chk("t2_grants", acc_own.size(), 4);
    chk("t2_rsps", rsp_vec.size(), 4);
    if (acc_own.size() == 4 && rsp_vec.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("t2_grant%0d", i), acc_own[i], exp_ord[i]);
        chk($sformatf("t2_rsp%0d", i), rsp_vec[i], 1 << exp_ord[i]);
      end
    end

    // 3: three wait states
    slv_waits = 3;
    clear_logs();
    push(1, 1'b1, 32'h40, 8'h3C);
    run_quiet(50);
    slv_waits = 0;
    chk("t3_penable_cycles", pen_cnt, 4);
    if (rsp_cyc.size() == 1 && acc_cyc.size() == 1) chk("t3_rsp_lat", rsp_cyc[0] - acc_cyc[0], 6);
    else chk("t3_rsp_count", rsp_cyc.size(), 1);

    // 4: slave error on a read by requester 1
    slv_err = 1'b1;
    clear_logs();
    push(1, 1'b0, 32'h14, 8'h00);
    run_quiet(50);
    slv_err = 1'b0;
    chk("t4_rsp_count", rsp_vec.size(), 1);
    if (rsp_vec.size() == 1) begin
      chk("t4_rsp_vec", rsp_vec[0], 2);
      chk("t4_rsp_err", rsp_er[0], 1);
      chk("t4_rsp_rdata", rsp_dat[0], 0);
    end

    // 5: asynchronous reset while in ACCESS
    slv_waits = 1000;
    clear_logs();
    push(0, 1'b0, 32'h20, 8'h00);
    wait_penable(20);
    step(); step();
    #2 preset = 1'b1;
    #1;
    chk("t5_async_psel", bus.psel, 0);
    chk("t5_async_penable", bus.penable, 0);
    q0.delete(); q1.delete();
    drive();
    repeat (3) step();
    preset = 1'b0;
    slv_waits = 0;
    chk("t5_no_rsp", rsp_vec.size(), 0);
    clear_logs();
    push(1, 1'b1, 32'h50, 8'h11);
    step();
    push(0, 1'b1, 32'h51, 8'h22);
    run_quiet(50);
    chk("t5_grants", acc_own.size(), 2);
    if (acc_own.size() == 2 && rsp_vec.size() == 2) begin
      chk("t5_first", acc_own[0], 1);
      chk("t5_second", acc_own[1], 0);
      chk("t5_rsp_first", rsp_vec[0], 2);
    end

    // 6: slave never ready
    slv_waits = 1000;
    clear_logs();
    push(0, 1'b1, 32'h60, 8'h77);
`ifdef APB_TIMEOUT_EN
    run_quiet(60);
    chk("t6_access_cycles", pen_cnt, TIMEOUT_CYCLES);
    chk("t6_rsp_count", rsp_vec.size(), 1);
    if (rsp_vec.size() == 1) begin
      chk("t6_rsp_vec", rsp_vec[0], 1);
      chk("t6_rsp_err", rsp_er[0], 1);
      chk("t6_rsp_rdata", rsp_dat[0], 0);
    end
`else
    repeat (30) step();
    chk("t6_penable_held", bus.penable, 1);
    chk("t6_psel_held", bus.psel, 1);
    chk("t6_no_rsp", rsp_vec.size(), 0);
    do_reset();
`endif
    slv_waits = 0;
    repeat (2) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
